// File: rtl/key_debounce_array_if.sv
// Key bundle between the debouncer and its consumer: raw keys in, filtered levels and event pulses out.
// No flow control; pulses are single-cycle and must be sampled every clock.
interface key_debounce_array_if #(
   parameter int N = 4
);
   logic [N-1:0] key_in;
   logic [N-1:0] key_state;
   logic [N-1:0] key_press;
   logic [N-1:0] key_release;
   logic [N-1:0] key_long;
   logic         key_any;

   modport master (
      output key_in,
      input  key_state, key_press, key_release, key_long, key_any
   );

   modport slave (
      input  key_in,
      output key_state, key_press, key_release, key_long, key_any
   );
endinterface

// File: rtl/key_debounce_array.sv
// N independent key debouncers with press/release/long-press pulses; press/release latency FILTER_CNT+2 clk.
// No backpressure: every output is a registered level or one-cycle pulse.
module key_debounce_array #(
   parameter int N          = 4,
   parameter int FILTER_CNT = 1_000_000,
   parameter int LONG_CNT   = 50_000_000
) (
   input logic                clk,
   input logic                rst,
   key_debounce_array_if.slave kb
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FILTER0 = 2'd1;
   localparam logic [1:0] DOWN    = 2'd2;
   localparam logic [1:0] FILTER1 = 2'd3;

   localparam int FCW = $clog2(FILTER_CNT);
   // hc must be able to hold LONG_CNT itself for saturation
   localparam int HCW = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;

   localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_CNT - 1);
   localparam logic [HCW-1:0] HC_MAX  = HCW'(LONG_CNT);
   localparam logic [HCW-1:0] HC_LAST = HCW'((LONG_CNT > 0) ? LONG_CNT - 1 : 0);

   logic [N-1:0]   sync1;
   logic [N-1:0]   sync2;
   logic [1:0]     st_q  [N];
   logic [1:0]     st_nx [N];
   logic [FCW-1:0] fc_q  [N];
   logic [FCW-1:0] fc_nx [N];
   logic [HCW-1:0] hc_q  [N];
   logic [HCW-1:0] hc_nx [N];
   logic [N-1:0]   state_nx;
   logic [N-1:0]   press_nx;
   logic [N-1:0]   rel_nx;
   logic [N-1:0]   long_nx;

   logic [N-1:0]   key_state_q;
   logic [N-1:0]   key_press_q;
   logic [N-1:0]   key_release_q;
   logic [N-1:0]   key_long_q;
   logic           key_any_q;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         st_nx[i]    = st_q[i];
         fc_nx[i]    = fc_q[i];
         hc_nx[i]    = hc_q[i];
         state_nx[i] = 1'b0;
         press_nx[i] = 1'b0;
         rel_nx[i]   = 1'b0;
         long_nx[i]  = 1'b0;

         case (st_q[i])
            IDLE: begin
               fc_nx[i] = '0;
               if (!sync2[i]) st_nx[i] = FILTER0;
            end
            FILTER0: begin
               if (sync2[i]) begin
                  st_nx[i] = IDLE;
                  fc_nx[i] = '0;
               end else if (fc_q[i] == FC_LAST) begin
                  st_nx[i]    = DOWN;
                  fc_nx[i]    = '0;
                  press_nx[i] = 1'b1;
               end else begin
                  fc_nx[i] = fc_q[i] + 1'b1;
               end
            end
            DOWN: begin
               fc_nx[i] = '0;
               if (sync2[i]) st_nx[i] = FILTER1;
            end
            FILTER1: begin
               if (!sync2[i]) begin
                  st_nx[i] = DOWN;
                  fc_nx[i] = '0;
               end else if (fc_q[i] == FC_LAST) begin
                  st_nx[i]  = IDLE;
                  fc_nx[i]  = '0;
                  rel_nx[i] = 1'b1;
               end else begin
                  fc_nx[i] = fc_q[i] + 1'b1;
               end
            end
            default: begin
               st_nx[i] = IDLE;
               fc_nx[i] = '0;
            end
         endcase

         // hold time keeps running through release bounces; only a fresh press restarts it
         if (LONG_CNT == 0) begin
            hc_nx[i] = '0;
         end else if (press_nx[i]) begin
            hc_nx[i] = '0;
         end else if ((st_q[i] == DOWN || st_q[i] == FILTER1) && hc_q[i] != HC_MAX) begin
            hc_nx[i] = hc_q[i] + 1'b1;
         end

         long_nx[i]  = (LONG_CNT != 0) && (hc_nx[i] == HC_LAST) &&
                       ((hc_q[i] != HC_LAST) || press_nx[i]);
         state_nx[i] = (st_nx[i] == DOWN) || (st_nx[i] == FILTER1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1         <= '1;
         sync2         <= '1;
         key_state_q   <= '0;
         key_press_q   <= '0;
         key_release_q <= '0;
         key_long_q    <= '0;
         key_any_q     <= 1'b0;
         for (int i = 0; i < N; i++) begin
            st_q[i] <= IDLE;
            fc_q[i] <= '0;
            hc_q[i] <= '0;
         end
      end else begin
         sync1         <= kb.key_in;
         sync2         <= sync1;
         key_state_q   <= state_nx;
         key_press_q   <= press_nx;
         key_release_q <= rel_nx;
         key_long_q    <= long_nx;
         key_any_q     <= |state_nx;
         for (int i = 0; i < N; i++) begin
            st_q[i] <= st_nx[i];
            fc_q[i] <= fc_nx[i];
            hc_q[i] <= hc_nx[i];
         end
      end
   end

   assign kb.key_state   = key_state_q;
   assign kb.key_press   = key_press_q;
   assign kb.key_release = key_release_q;
   assign kb.key_long    = key_long_q;
   assign kb.key_any     = key_any_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array with N=2, FILTER_CNT=8, LONG_CNT=32.
module tb_key_debounce_array;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   key_debounce_array_if #(.N(2)) kb ();

   key_debounce_array #(
      .N          (2),
      .FILTER_CNT (8),
      .LONG_CNT   (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kb  (kb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      kb.key_in = 2'b11;
      tick();
      tick();
      checks++; if (kb.key_state !== 2'b00) begin errors++; $display("FAIL reset key_state: got %b expected 00", kb.key_state); end
      checks++; if (kb.key_press !== 2'b00) begin errors++; $display("FAIL reset key_press: got %b expected 00", kb.key_press); end
      checks++; if (kb.key_release !== 2'b00) begin errors++; $display("FAIL reset key_release: got %b expected 00", kb.key_release); end
      checks++; if (kb.key_long !== 2'b00) begin errors++; $display("FAIL reset key_long: got %b expected 00", kb.key_long); end
      checks++; if (kb.key_any !== 1'b0) begin errors++; $display("FAIL reset key_any: got %b expected 0", kb.key_any); end
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (kb.key_state !== 2'b00) begin errors++; $display("FAIL idle key_state k=%0d: got %b expected 00", k, kb.key_state); end
      end
   endtask

   task automatic test_clean_press();
      logic [1:0] exp_state;
      logic [1:0] exp_pulse;
      kb.key_in = 2'b10;
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_state = (k >= 10) ? 2'b01 : 2'b00;
         exp_pulse = (k == 10) ? 2'b01 : 2'b00;
         checks++; if (kb.key_state !== exp_state) begin errors++; $display("FAIL press key_state k=%0d: got %b expected %b", k, kb.key_state, exp_state); end
         checks++; if (kb.key_press !== exp_pulse) begin errors++; $display("FAIL press key_press k=%0d: got %b expected %b", k, kb.key_press, exp_pulse); end
         checks++; if (kb.key_any !== (k >= 10)) begin errors++; $display("FAIL press key_any k=%0d: got %b expected %b", k, kb.key_any, (k >= 10)); end
      end
      kb.key_in = 2'b11;
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_state = (k < 10) ? 2'b01 : 2'b00;
         exp_pulse = (k == 10) ? 2'b01 : 2'b00;
         checks++; if (kb.key_state !== exp_state) begin errors++; $display("FAIL release key_state k=%0d: got %b expected %b", k, kb.key_state, exp_state); end
         checks++; if (kb.key_release !== exp_pulse) begin errors++; $display("FAIL release key_release k=%0d: got %b expected %b", k, kb.key_release, exp_pulse); end
         checks++; if (kb.key_long !== 2'b00) begin errors++; $display("FAIL release key_long k=%0d: got %b expected 00", k, kb.key_long); end
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 15; k++) begin
         kb.key_in = (k < 5) ? 2'b10 : 2'b11;
         tick();
         checks++; if (kb.key_state !== 2'b00) begin errors++; $display("FAIL glitch key_state k=%0d: got %b expected 00", k, kb.key_state); end
         checks++; if (kb.key_press !== 2'b00) begin errors++; $display("FAIL glitch key_press k=%0d: got %b expected 00", k, kb.key_press); end
      end
   endtask

   task automatic test_release_bounce();
      logic [1:0] exp_state;
      logic [1:0] exp_pulse;
      kb.key_in = 2'b10;
      repeat (11) tick();
      checks++; if (kb.key_press !== 2'b01) begin errors++; $display("FAIL bounce setup key_press: got %b expected 01", kb.key_press); end
      tick();
      tick();
      for (int k = 0; k < 8; k++) begin
         kb.key_in = (k < 3) ? 2'b11 : 2'b10;
         tick();
         checks++; if (kb.key_state !== 2'b01) begin errors++; $display("FAIL bounce key_state k=%0d: got %b expected 01", k, kb.key_state); end
         checks++; if (kb.key_release !== 2'b00) begin errors++; $display("FAIL bounce key_release k=%0d: got %b expected 00", k, kb.key_release); end
      end
      kb.key_in = 2'b11;
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_state = (k < 10) ? 2'b01 : 2'b00;
         exp_pulse = (k == 10) ? 2'b01 : 2'b00;
         checks++; if (kb.key_state !== exp_state) begin errors++; $display("FAIL bounce final key_state k=%0d: got %b expected %b", k, kb.key_state, exp_state); end
         checks++; if (kb.key_release !== exp_pulse) begin errors++; $display("FAIL bounce final key_release k=%0d: got %b expected %b", k, kb.key_release, exp_pulse); end
         checks++; if (kb.key_long !== 2'b00) begin errors++; $display("FAIL bounce key_long k=%0d: got %b expected 00", k, kb.key_long); end
      end
   endtask

   task automatic test_long_press();
      logic [1:0] exp_long;
      kb.key_in = 2'b10;
      repeat (11) tick();
      checks++; if (kb.key_press !== 2'b01) begin errors++; $display("FAIL long setup key_press: got %b expected 01", kb.key_press); end
      for (int k = 1; k <= 60; k++) begin
         kb.key_in = (k >= 40 && k <= 42) ? 2'b11 : 2'b10;
         tick();
         exp_long = (k == 31) ? 2'b01 : 2'b00;
         checks++; if (kb.key_long !== exp_long) begin errors++; $display("FAIL long key_long k=%0d: got %b expected %b", k, kb.key_long, exp_long); end
         checks++; if (kb.key_state !== 2'b01) begin errors++; $display("FAIL long key_state k=%0d: got %b expected 01", k, kb.key_state); end
         checks++; if (kb.key_release !== 2'b00) begin errors++; $display("FAIL long key_release k=%0d: got %b expected 00", k, kb.key_release); end
      end
      kb.key_in = 2'b11;
      for (int k = 0; k < 11; k++) begin
         tick();
         checks++; if (kb.key_long !== 2'b00) begin errors++; $display("FAIL long tail key_long k=%0d: got %b expected 00", k, kb.key_long); end
      end
      checks++; if (kb.key_release !== 2'b01) begin errors++; $display("FAIL long key_release: got %b expected 01", kb.key_release); end
      checks++; if (kb.key_state !== 2'b00) begin errors++; $display("FAIL long end key_state: got %b expected 00", kb.key_state); end
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp_pulse;
      kb.key_in = 2'b00;
      for (int k = 0; k < 11; k++) begin
         tick();
         exp_pulse = (k == 10) ? 2'b11 : 2'b00;
         checks++; if (kb.key_press !== exp_pulse) begin errors++; $display("FAIL simul key_press k=%0d: got %b expected %b", k, kb.key_press, exp_pulse); end
         checks++; if (kb.key_any !== (k == 10)) begin errors++; $display("FAIL simul key_any k=%0d: got %b expected %b", k, kb.key_any, (k == 10)); end
      end
      kb.key_in = 2'b11;
      repeat (11) tick();
      checks++; if (kb.key_release !== 2'b11) begin errors++; $display("FAIL simul key_release: got %b expected 11", kb.key_release); end
      checks++; if (kb.key_any !== 1'b0) begin errors++; $display("FAIL simul release key_any: got %b expected 0", kb.key_any); end
   endtask

   task automatic test_reset_mid_press();
      logic [1:0] exp_pulse;
      kb.key_in = 2'b10;
      repeat (11) tick();
      checks++; if (kb.key_state !== 2'b01) begin errors++; $display("FAIL rstmid setup key_state: got %b expected 01", kb.key_state); end
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++; if (kb.key_state !== 2'b00) begin errors++; $display("FAIL rstmid key_state: got %b expected 00", kb.key_state); end
      checks++; if (kb.key_any !== 1'b0) begin errors++; $display("FAIL rstmid key_any: got %b expected 0", kb.key_any); end
      checks++; if (kb.key_release !== 2'b00) begin errors++; $display("FAIL rstmid key_release: got %b expected 00", kb.key_release); end
      tick();
      checks++; if (kb.key_release !== 2'b00) begin errors++; $display("FAIL rstmid held key_release: got %b expected 00", kb.key_release); end
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         exp_pulse = (k == 10) ? 2'b01 : 2'b00;
         checks++; if (kb.key_press !== exp_pulse) begin errors++; $display("FAIL rstmid key_press k=%0d: got %b expected %b", k, kb.key_press, exp_pulse); end
         checks++; if (kb.key_release !== 2'b00) begin errors++; $display("FAIL rstmid after key_release k=%0d: got %b expected 00", k, kb.key_release); end
      end
      kb.key_in = 2'b11;
      repeat (11) tick();
      checks++; if (kb.key_release !== 2'b01) begin errors++; $display("FAIL rstmid final key_release: got %b expected 01", kb.key_release); end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      kb.key_in = 2'b11;
      test_reset();
      test_clean_press();
      test_glitch();
      test_release_bounce();
      test_long_press();
      test_simultaneous();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
